// File: rtl/mem_handshake_responder.sv
// rtl/mem_handshake_responder.sv - memory-side MOV/MOC responder with wait states and big-endian byte storage
// Optional feature macro: MEM_ALIGN_CHECK_EN (flags and suppresses misaligned half/word accesses)
module mem_handshake_responder #(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  typeData,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        MOC,
   output logic        ALIGN_ERR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);
   localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rw;
   logic [1:0]        r_size;
   logic [31:0]       r_wdata;
   logic [3:0]        r_cnt;
   logic [31:0]       r_dout;

   logic [7:0]        mem [0:DEPTH-1];

   logic [ADDR_W-1:0] w_idx0;
   logic [ADDR_W-1:0] w_idx1;
   logic [ADDR_W-1:0] w_idx2;
   logic [ADDR_W-1:0] w_idx3;
   logic [31:0]       w_rdata;
   logic              w_misaligned;
   logic              w_do_write;
   logic              w_unused_addr;

   assign w_unused_addr = ^Address[31:ADDR_W];

   // Index arithmetic is ADDR_W wide so a+1..a+3 wrap naturally at DEPTH
   assign w_idx0 = r_addr;
   assign w_idx1 = r_addr + ADDR_W'(1);
   assign w_idx2 = r_addr + ADDR_W'(2);
   assign w_idx3 = r_addr + ADDR_W'(3);

   always_comb begin
      w_rdata = 32'h0;
      case (r_size)
         2'b00:   w_rdata = {24'h0, mem[w_idx0]};
         2'b01:   w_rdata = {16'h0, mem[w_idx0], mem[w_idx1]};
         default: w_rdata = {mem[w_idx0], mem[w_idx1], mem[w_idx2], mem[w_idx3]};
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic r_align_err;

   assign w_misaligned = ((r_size == 2'b01) && r_addr[0]) ||
                         (r_size[1] && (r_addr[1:0] != 2'b00));

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_align_err <= 1'b0;
      end else if (r_state == S_ACCESS) begin
         r_align_err <= w_misaligned;
      end else if ((r_state == S_DONE) && !MOV) begin
         r_align_err <= 1'b0;
      end
   end

   assign ALIGN_ERR = r_align_err;
`else
   assign w_misaligned = 1'b0;
   assign ALIGN_ERR    = 1'b0;
`endif

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (MOV) begin
               w_next_state = HAS_WAIT ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (r_cnt == WAIT_CNT) begin
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_next_state = S_DONE;
         end
         S_DONE: begin
            if (!MOV) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_addr  <= '0;
         r_rw    <= 1'b1;
         r_size  <= 2'b00;
         r_wdata <= 32'h0;
         r_cnt   <= 4'd0;
         r_dout  <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (MOV) begin
                  r_addr  <= Address[ADDR_W-1:0];
                  r_rw    <= RW;
                  r_size  <= typeData;
                  r_wdata <= DataIn;
                  r_cnt   <= 4'd0;
               end
            end
            S_WAIT: begin
               if (r_cnt != WAIT_CNT) begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_ACCESS: begin
               if (w_misaligned) begin
                  r_dout <= 32'h0;
               end else if (r_rw) begin
                  r_dout <= w_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Storage has no reset; CLR only guards against a write racing the reset edge
   assign w_do_write = (r_state == S_ACCESS) && !r_rw && !w_misaligned && !CLR;

   always_ff @(posedge CLK) begin
      if (w_do_write) begin
         case (r_size)
            2'b00: begin
               mem[w_idx0] <= r_wdata[7:0];
            end
            2'b01: begin
               mem[w_idx0] <= r_wdata[15:8];
               mem[w_idx1] <= r_wdata[7:0];
            end
            default: begin
               mem[w_idx0] <= r_wdata[31:24];
               mem[w_idx1] <= r_wdata[23:16];
               mem[w_idx2] <= r_wdata[15:8];
               mem[w_idx3] <= r_wdata[7:0];
            end
         endcase
      end
   end

   assign DataOut = r_dout;
   assign MOC     = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_handshake_responder.sv
// tb/tb_mem_handshake_responder.sv - directed vector bench for mem_handshake_responder (WAIT_CYCLES=2)
module tb_mem_handshake_responder;

   logic        CLK;
   logic        CLR;
   logic        MOV;
   logic        RW;
   logic [1:0]  typeData;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MOC;
   logic        ALIGN_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   mem_handshake_responder #(
      .DEPTH(256),
      .ADDR_W(8),
      .WAIT_CYCLES(2)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .MOV(MOV),
      .RW(RW),
      .typeData(typeData),
      .Address(Address),
      .DataIn(DataIn),
      .DataOut(DataOut),
      .MOC(MOC),
      .ALIGN_ERR(ALIGN_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rw;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_dout;
      logic        exp_ae;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; returns number of edges after capture until MOC seen (-1 on timeout)
   task automatic start_wait(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, output int edges);
      int lat;
      MOV = 1'b1; RW = rw; typeData = sz; Address = addr; DataIn = wd;
      lat = 0;
      edges = -1;
      while (lat < 30) begin
         @(negedge CLK);
         lat++;
         if (MOC) begin
            edges = lat - 1;
            break;
         end
      end
   endtask

   task automatic release_chk(input string name);
      MOV = 1'b0;
      RW = 1'b1; Address = 32'hFFFF_FFFF; DataIn = 32'hFFFF_FFFF;
      @(negedge CLK);
      chk({name, "_moc_low"}, {31'h0, MOC}, 32'h0);
      chk({name, "_ae_low"}, {31'h0, ALIGN_ERR}, 32'h0);
   endtask

   initial begin
      int edges;

      vecs[0]  = '{1'b1, 2'b10, 32'd0,          32'h0,        32'hE3A01005, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 32'd5,          32'h0000_00AB, 32'hE3A01005, 1'b0};
      vecs[2]  = '{1'b1, 2'b01, 32'd4,          32'h0,        32'h000012AB, 1'b0};
      vecs[3]  = '{1'b1, 2'b00, 32'd6,          32'h0,        32'h00000006, 1'b0};
      vecs[4]  = '{1'b1, 2'b00, 32'd7,          32'h0,        32'h00000007, 1'b0};
      vecs[5]  = '{1'b0, 2'b10, 32'd252,        32'hDEADBEEF, 32'h00000007, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 32'd252,        32'h0,        32'hDEADBEEF, 1'b0};
      vecs[7]  = '{1'b1, 2'b00, 32'd0,          32'h0,        32'h000000E3, 1'b0};
      vecs[8]  = '{1'b1, 2'b01, 32'd254,        32'h0,        32'h0000BEEF, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
      vecs[9]  = '{1'b1, 2'b10, 32'd254,        32'h0,        32'h00000000, 1'b1};
`else
      vecs[9]  = '{1'b1, 2'b10, 32'd254,        32'h0,        32'hBEEFE3A0, 1'b0};
`endif
      vecs[10] = '{1'b1, 2'b11, 32'd8,          32'h0,        32'h08090A0B, 1'b0};
      vecs[11] = '{1'b0, 2'b01, 32'd16,         32'h1234C0DE, 32'h08090A0B, 1'b0};
      vecs[12] = '{1'b0, 2'b00, 32'd18,         32'hFFFFFF5A, 32'h08090A0B, 1'b0};
      vecs[13] = '{1'b1, 2'b10, 32'd16,         32'h0,        32'hC0DE5A13, 1'b0};
      vecs[14] = '{1'b1, 2'b00, 32'h1234_5600,  32'h0,        32'h000000E3, 1'b0};

      CLR = 1'b1; MOV = 1'b0; RW = 1'b1; typeData = 2'b00; Address = 32'h0; DataIn = 32'h0;
      for (int i = 0; i < 256; i++) dut.mem[i] = 8'(i);
      dut.mem[0] = 8'hE3; dut.mem[1] = 8'hA0; dut.mem[2] = 8'h10;
      dut.mem[3] = 8'h05; dut.mem[4] = 8'h12;

      repeat (2) @(negedge CLK);
      chk("rst_moc", {31'h0, MOC}, 32'h0);
      chk("rst_dout", DataOut, 32'h0);
      chk("rst_ae", {31'h0, ALIGN_ERR}, 32'h0);
      CLR = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 15; i++) begin
         start_wait(vecs[i].rw, vecs[i].sz, vecs[i].addr, vecs[i].wd, edges);
         chk($sformatf("v%0d_latency", i), 32'(edges), 32'd4);
         chk($sformatf("v%0d_dout", i), DataOut, vecs[i].exp_dout);
         chk($sformatf("v%0d_ae", i), {31'h0, ALIGN_ERR}, {31'h0, vecs[i].exp_ae});
         release_chk($sformatf("v%0d", i));
      end
      chk("mem6_7_untouched", {16'h0, dut.mem[6], dut.mem[7]}, 32'h00000607);

      // MOV held high after MOC: response must stay put, then back-to-back request
      start_wait(1'b1, 2'b10, 32'd0, 32'h0, edges);
      chk("hold_latency", 32'(edges), 32'd4);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk($sformatf("hold%0d_moc", k), {31'h0, MOC}, 32'h1);
         chk($sformatf("hold%0d_dout", k), DataOut, 32'hE3A01005);
      end
      release_chk("hold");
      start_wait(1'b1, 2'b00, 32'd4, 32'h0, edges);
      chk("b2b_latency", 32'(edges), 32'd4);
      chk("b2b_dout", DataOut, 32'h00000012);
      release_chk("b2b");

      // MOV dropped during WAIT: request completes, DONE lasts one cycle
      MOV = 1'b1; RW = 1'b1; typeData = 2'b00; Address = 32'd1;
      @(negedge CLK);
      MOV = 1'b0;
      edges = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (MOC) begin
            edges = k + 1;
            break;
         end
      end
      chk("drop_latency", 32'(edges), 32'd4);
      chk("drop_dout", DataOut, 32'h000000A0);
      @(negedge CLK);
      chk("drop_moc_low", {31'h0, MOC}, 32'h0);

      // Misaligned word read @2
      start_wait(1'b1, 2'b10, 32'd2, 32'h0, edges);
      chk("mis_latency", 32'(edges), 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_dout", DataOut, 32'h00000000);
      chk("mis_ae", {31'h0, ALIGN_ERR}, 32'h1);
`else
      chk("mis_dout", DataOut, 32'h100512AB);
      chk("mis_ae", {31'h0, ALIGN_ERR}, 32'h0);
`endif
      release_chk("mis");

      // CLR during WAIT of a word write @8
      MOV = 1'b1; RW = 1'b0; typeData = 2'b10; Address = 32'd8; DataIn = 32'h11223344;
      @(negedge CLK);
      CLR = 1'b1;
      #1;
      chk("clr_moc", {31'h0, MOC}, 32'h0);
      chk("clr_dout", DataOut, 32'h0);
      MOV = 1'b0;
      @(negedge CLK);
      CLR = 1'b0;
      repeat (6) @(negedge CLK);
      chk("clr_moc_idle", {31'h0, MOC}, 32'h0);
      chk("clr_mem8_11", {dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]}, 32'h08090A0B);
      start_wait(1'b1, 2'b10, 32'd8, 32'h0, edges);
      chk("clr_read_latency", 32'(edges), 32'd4);
      chk("clr_read_dout", DataOut, 32'h08090A0B);
      release_chk("clr_read");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
